// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg
// Brief    : Shared types and helpers for the instruction loader.
// Revision : 1.0  initial release
// ============================================================================
package loader_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FILL = 3'd2,
    HOLD = 3'd3,
    RUN  = 3'd4
  } ldr_state_e;

  // A load length is usable when it names at least one entry and fits the store.
  function automatic logic count_in_range(input int count, input int num_instr);
    return (count != 0) && (count <= num_instr);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Brief    : Streams program words into the core's instruction store,
//            zero-fills the unused tail and holds the core in reset until
//            the store is complete.
// Revision : 1.0  initial release
// ============================================================================
import loader_pkg::*;

module instr_loader #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_INSTR = 10,
  parameter int CNT_WIDTH = $clog2(NUM_INSTR + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_count,
  input  logic                 i_valid,
  input  logic [REG_WIDTH-1:0] i_data,
  output logic                 o_ready,
  output logic [REG_WIDTH-1:0] o_instructions [NUM_INSTR],
  output logic                 o_core_rst,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error
);

  localparam int INSTR_SELECT = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
  localparam logic [INSTR_SELECT-1:0] c_last_idx  = INSTR_SELECT'(NUM_INSTR - 1);
  localparam logic [INSTR_SELECT-1:0] c_ptr_one   = INSTR_SELECT'(1);
  localparam logic [CNT_WIDTH-1:0]    c_num_instr = CNT_WIDTH'(NUM_INSTR);
  localparam logic [CNT_WIDTH-1:0]    c_cnt_one   = CNT_WIDTH'(1);

  ldr_state_e              r_state;
  ldr_state_e              w_state_nxt;
  logic [INSTR_SELECT-1:0] r_ptr;
  logic [INSTR_SELECT-1:0] w_ptr_nxt;
  logic [CNT_WIDTH-1:0]    r_count;
  logic [REG_WIDTH-1:0]    r_store [NUM_INSTR];

  logic                    r_ready;
  logic                    r_core_rst;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_error;

  logic                    w_start_ok;
  logic                    w_hs;
  logic                    w_last_word;
  logic                    w_fill_last;
  logic                    w_err_nxt;
  logic                    w_wr;
  logic [REG_WIDTH-1:0]    w_wdata;

  assign w_start_ok  = i_start && count_in_range(32'(i_count), NUM_INSTR);
  // r_ready is registered together with the state, so it is high exactly in LOAD.
  assign w_hs        = i_valid && r_ready;
  assign w_last_word = w_hs && ((CNT_WIDTH'(r_ptr) + c_cnt_one) == r_count);
  assign w_fill_last = (r_state == FILL) && (r_ptr == c_last_idx);
  assign w_wr        = w_hs || (r_state == FILL);
  assign w_wdata     = (r_state == FILL) ? '0 : i_data;

  // Next state, next pointer and rejected-start detection.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE, RUN: begin
        if (i_start) begin
          if (w_start_ok) begin
            w_state_nxt = LOAD;
            w_ptr_nxt   = '0;
          end else begin
            w_err_nxt   = 1'b1;
          end
        end
      end
      LOAD: begin
        if (w_hs) begin
          // A full-length load has no tail to clear; the pointer parks at 0
          // instead of stepping past the last entry.
          if (w_last_word && (r_count == c_num_instr)) begin
            w_state_nxt = HOLD;
            w_ptr_nxt   = '0;
          end else begin
            w_ptr_nxt   = r_ptr + c_ptr_one;
            if (w_last_word) w_state_nxt = FILL;
          end
        end
      end
      FILL: begin
        if (w_fill_last) begin
          w_state_nxt = HOLD;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt   = r_ptr + c_ptr_one;
        end
      end
      HOLD:    w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sequencer state and outputs. o_ready/o_error track the state being entered;
  // reset/busy/done decode the current state, so the core leaves reset one
  // cycle after HOLD has presented the final store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_error    <= 1'b0;
      r_core_rst <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      if (((r_state == IDLE) || (r_state == RUN)) && w_start_ok) r_count <= i_count;
      r_ready    <= (w_state_nxt == LOAD);
      r_error    <= w_err_nxt;
      r_core_rst <= (r_state != RUN);
      r_busy     <= (r_state == LOAD) || (r_state == FILL) || (r_state == HOLD);
      r_done     <= (r_state == RUN);
    end
  end

  // Instruction store: one entry written per cycle at the pointer, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_INSTR; k++) r_store[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_INSTR; k++) begin
        if (w_wr && (r_ptr == INSTR_SELECT'(k))) r_store[k] <= w_wdata;
      end
    end
  end

  assign o_instructions = r_store;
  assign o_ready        = r_ready;
  assign o_error        = r_error;
  assign o_core_rst     = r_core_rst;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_loader
// Brief    : Self-checking bench for instr_loader: vector table of loads,
//            hand-written reset sequences and randomized loads against a
//            store model.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_loader;

  localparam int REG_WIDTH = 32;
  localparam int NUM_INSTR = 10;
  localparam int CNT_WIDTH = 4;

  logic                 clk     = 1'b0;
  logic                 rst     = 1'b1;
  logic                 i_start = 1'b0;
  logic [CNT_WIDTH-1:0] i_count = '0;
  logic                 i_valid = 1'b0;
  logic [REG_WIDTH-1:0] i_data  = '0;
  logic                 o_ready;
  logic [REG_WIDTH-1:0] o_instructions [NUM_INSTR];
  logic                 o_core_rst;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_error;

  instr_loader #(
    .REG_WIDTH (REG_WIDTH),
    .NUM_INSTR (NUM_INSTR),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_count        (i_count),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .o_ready        (o_ready),
    .o_instructions (o_instructions),
    .o_core_rst     (o_core_rst),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Words to stream for the next load, and the expected store contents.
  logic [REG_WIDTH-1:0] tb_words [NUM_INSTR];
  logic [REG_WIDTH-1:0] m_store  [NUM_INSTR];

  typedef struct {
    int                   cnt;
    int                   gap;
    logic [REG_WIDTH-1:0] base;
    logic [REG_WIDTH-1:0] step;
    bit                   exp_err;
    int                   exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_store(input string name);
    for (int k = 0; k < NUM_INSTR; k++)
      chk($sformatf("%s[%0d]", name, k), o_instructions[k], m_store[k]);
  endtask

  // Model of a completed load: streamed words at the front, zeros behind.
  task automatic model_load(input int cnt);
    for (int k = 0; k < NUM_INSTR; k++) m_store[k] = (k < cnt) ? tb_words[k] : '0;
  endtask

  task automatic do_load(input int cnt, input int gap, input bit exp_err, input int exp_lat);
    logic prev_done;
    logic err_seen;
    int   n;
    prev_done = o_done;
    @(negedge clk);
    i_start = 1'b1;
    i_count = CNT_WIDTH'(cnt);
    @(negedge clk);
    i_start = 1'b0;
    i_count = '0;
    if (exp_err) begin
      chk("reject_error_pulse", o_error, 1'b1);
      chk("reject_ready", o_ready, 1'b0);
      chk("reject_state_kept", o_done, prev_done);
      @(negedge clk);
      chk("reject_error_clear", o_error, 1'b0);
      check_store("reject_store");
    end else begin
      chk("start_ready", o_ready, 1'b1);
      for (int w = 0; w < cnt; w++) begin
        repeat (gap) begin
          i_valid = 1'b0;
          i_data  = $urandom;
          @(negedge clk);
        end
        i_valid = 1'b1;
        i_data  = tb_words[w];
        @(negedge clk);
        if (w == 0) begin
          chk("load_core_rst", o_core_rst, 1'b1);
          chk("load_busy", o_busy, 1'b1);
        end
        if (w < cnt - 1) chk("load_ready_mid", o_ready, 1'b1);
      end
      chk("ready_after_last", o_ready, 1'b0);
      // An extra word is offered and a start is pulsed during the tail; both must be ignored.
      i_valid  = 1'b1;
      i_data   = 32'hDEAD_BEEF;
      n        = 0;
      err_seen = 1'b0;
      if (cnt < NUM_INSTR) begin
        i_start = 1'b1;
        i_count = CNT_WIDTH'(5);
      end
      while (o_core_rst === 1'b1 && n < 40) begin
        @(negedge clk);
        i_valid = 1'b0;
        i_start = 1'b0;
        i_count = '0;
        n++;
        if (o_error === 1'b1) err_seen = 1'b1;
      end
      chk("core_rst_latency", n, exp_lat);
      chk("run_done", o_done, 1'b1);
      chk("run_busy", o_busy, 1'b0);
      chk("no_error_in_tail", err_seen, 1'b0);
      model_load(cnt);
      check_store("load_store");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Expected core-release latency = (NUM_INSTR - count) + 2 edges after the last handshake.
    vecs[0] = '{10, 0, 32'hA0, 32'h01, 1'b0,  2};
    vecs[1] = '{ 3, 2, 32'h11, 32'h11, 1'b0,  9};
    vecs[2] = '{ 0, 0, 32'h00, 32'h00, 1'b1,  0};
    vecs[3] = '{11, 0, 32'h00, 32'h00, 1'b1,  0};
    vecs[4] = '{ 2, 0, 32'hB0, 32'h01, 1'b0, 10};
    vecs[5] = '{15, 0, 32'h00, 32'h00, 1'b1,  0};
    vecs[6] = '{ 1, 1, 32'h5A5A_0001, 32'h01, 1'b0, 11};

    // Asynchronous reset between edges.
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < NUM_INSTR; k++) m_store[k] = '0;
    chk("reset_core_rst", o_core_rst, 1'b1);
    chk("reset_ready", o_ready, 1'b0);
    chk("reset_done", o_done, 1'b0);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_error", o_error, 1'b0);
    check_store("reset_store");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Vectors 2/3 are rejected in IDLE; vectors 4/5 start from RUN.
    // Vector 0 has to run first so later loads hit a non-empty store.
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < NUM_INSTR; k++) tb_words[k] = vecs[v].base + vecs[v].step * k;
      if (v == 2) begin
        // Bad starts are exercised from IDLE: return to IDLE through reset first.
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < NUM_INSTR; k++) m_store[k] = '0;
        @(negedge clk);
        rst = 1'b1;
      end
      do_load(vecs[v].cnt, vecs[v].gap, vecs[v].exp_err, vecs[v].exp_lat);
      if (v == 3) begin
        // Restore a full store so the reload from RUN has old entries to overwrite.
        for (int k = 0; k < NUM_INSTR; k++) tb_words[k] = 32'hA0 + k;
        do_load(10, 0, 1'b0, 2);
      end
    end

    // Asynchronous reset in the middle of a full load.
    for (int k = 0; k < NUM_INSTR; k++) tb_words[k] = 32'hC0 + k;
    @(negedge clk);
    i_start = 1'b1;
    i_count = CNT_WIDTH'(10);
    @(negedge clk);
    i_start = 1'b0;
    i_count = '0;
    for (int w = 0; w < 4; w++) begin
      i_valid = 1'b1;
      i_data  = tb_words[w];
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk("midload_entry3", o_instructions[3], 32'hC3);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < NUM_INSTR; k++) m_store[k] = '0;
    chk("midrst_ready", o_ready, 1'b0);
    chk("midrst_core_rst", o_core_rst, 1'b1);
    chk("midrst_done", o_done, 1'b0);
    chk("midrst_busy", o_busy, 1'b0);
    check_store("midrst_store");
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NUM_INSTR; k++) tb_words[k] = 32'hD0 + k;
    do_load(10, 0, 1'b0, 2);

    // Randomized loads, including out-of-range counts rejected from RUN.
    for (int r = 0; r < 12; r++) begin
      int cnt;
      cnt = $urandom_range(0, 15);
      for (int k = 0; k < NUM_INSTR; k++) tb_words[k] = $urandom;
      do_load(cnt, $urandom_range(0, 2), (cnt == 0) || (cnt > NUM_INSTR),
              (NUM_INSTR - cnt) + 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
